fft_out_reorder: RTL and testbench
==================================

# fft_out_reorder

Output-side companion of the 4-lane parallel FFT datapath: it consumes the four complex results the FFT emits per cycle under its output enable, undoes the bit-reversed output ordering, and delivers each frame in natural order, four bins per beat, over a valid/ready stream. It sits directly after the FFT core's output registers. A two-bank ping-pong buffer lets one frame be written while the previous one is read.

## Interface
- NBITS_out, 15, width of each real/imag part (two's complement).
- N, 32, FFT points per frame; power of two, N >= 8.
- LOG2N, $clog2(N), derived; do not override.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_enable  in  1  input beat valid; connect to the FFT o_enable.
- i_fft0_up, i_fft0_down, i_fft1_up, i_fft1_down  in  2*NBITS_out each  lanes 0..3; {re, im}, re in the upper half.
- i_ready  in  1  downstream accepts the current output beat.
- o_data0..o_data3  out  2*NBITS_out each  natural-order bins 4m..4m+3 of output beat m.
- o_valid  out  1  output beat valid.
- o_sof  out  1  high with beat 0 of a frame.
- o_eof  out  1  high with beat N/4-1 of a frame.
- o_overflow  out  1  sticky: at least one frame dropped.

## Operation
- Arrival index of lane l (0..3) in input beat k (0..N/4-1) is a = 4k+l. Natural bin is bitrev_LOG2N(a).
- Write side:
  - wr_cnt (0..N/4-1) and wr_bank.
  - The first i_enable beat after reset is beat 0 of frame 0.
  - When i_enable=1, lane l is written to bank[wr_bank][bitrev(4*wr_cnt+l)], then wr_cnt increments.
  - When i_enable=0, wr_cnt and the bank contents hold. Gaps are allowed anywhere in a frame.
  - After beat N/4-1 is written, full[wr_bank] is set, wr_bank toggles and wr_cnt returns to 0.
- Write FSM: WRITE / DROP.
  - The decision is taken at beat 0 of each frame.
  - If full[wr_bank]=1 and that bank is not being freed in the same cycle, enter DROP.
  - In DROP: no writes for the whole frame, o_overflow is set, and wr_bank is unchanged.
  - After beat N/4-1 in DROP, return to WRITE.
  - A bank freed in the same cycle as a beat 0 counts as free and is written.
- Read FSM: IDLE / SEND.
  - IDLE -> SEND when full[rd_bank]=1.
  - In SEND: o_data_l = bank[rd_bank][4*rd_cnt+l], o_valid=1, o_sof=(rd_cnt==0), o_eof=(rd_cnt==N/4-1).
  - rd_cnt advances only when o_valid && i_ready.
  - When the last beat is accepted: clear full[rd_bank], toggle rd_bank, rd_cnt=0. Go to SEND again if the other bank is full, otherwise to IDLE.
- While o_valid=1 and i_ready=0, o_data, o_sof and o_eof are held stable.
- When o_valid=0, o_data, o_sof and o_eof are driven to 0.
- Widths pass through unchanged; there is no arithmetic on the data.

## Timing
- Reset (rst=0, asynchronous): o_valid=0, o_sof=0, o_eof=0, o_overflow=0, o_data*=0. Also wr_cnt=rd_cnt=0, wr_bank=rd_bank=0, both full flags 0, FSMs in WRITE and IDLE. Partial frames are discarded. Buffer contents need not be cleared.
- Latency: last input beat written at edge t, o_valid=1 with beat 0 after edge t+1.
- Throughput: with i_ready held at 1 and contiguous input, back-to-back frames stream with no bubbles after the first and no overflow.
- o_overflow is cleared only by reset.
- Simultaneous write into bank X while bank Y is read is always legal; the FSMs never target the same bank with both a write and a read.

## Structure
- Shared package fft_pkg holds:
  - NBITS_out and N defaults, LOG2N, and LANES=4.
  - The {re, im} packing convention.
  - A bitrev(value, nbits) function.
- Natural sub-module fft_pingpong_mem: 2 x N words of 2*NBITS_out, 4 scattered write ports, 4 contiguous read ports, register-array implementation. The FSMs, counters and flags stay in fft_out_reorder.

## Test plan
- Reset: hold rst=0 with random inputs and i_enable=1 -> all outputs 0 and o_overflow=0.
- Single frame, N=32, each input re=a, im=0: 8 contiguous beats, i_ready=1 -> o_valid one cycle after the last beat. Beat 0 = {0,16,8,24}, beat 1 = {4,20,12,28}, ..., beat 7 = {7,23,15,31}. o_sof on beat 0, o_eof on beat 7.
- Gapped input: same frame with i_enable=0 for 3 cycles after beat 4 -> output identical to the single-frame case.
- Streaming: 4 frames back-to-back, i_ready=1 -> 32 contiguous o_valid beats after the first latency, correct order per frame, o_overflow=0.
- Backpressure and overflow, i_ready=0 from start: frames 0 and 1 are stored; frame 2 enters DROP and o_overflow=1 at its beat 0. Then raise i_ready -> frames 0 and 1 are delivered intact, frame 2 never appears, and frame 3 (arriving after bank 0 frees) is delivered.
- Reset mid-frame: rst=0 for one cycle at input beat 3 of frame 0, then a fresh frame -> only the fresh frame is output, in correct order, with o_overflow=0.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the 4-lane FFT output path: default sizes, the
// {re, im} word packing, FSM state types and a bit-reversal helper.
package fft_pkg;

  localparam int unsigned NBITS_OUT_DEF = 15;
  localparam int unsigned N_DEF         = 32;
  localparam int unsigned LOG2N_DEF     = $clog2(N_DEF);
  localparam int unsigned LANES         = 4;

  // One complex sample: real part in the upper half, imaginary in the lower.
  typedef struct packed {
    logic signed [NBITS_OUT_DEF-1:0] re;
    logic signed [NBITS_OUT_DEF-1:0] im;
  } cplx_t;

  typedef enum logic {
    WR_WRITE,
    WR_DROP
  } wr_state_e;

  typedef enum logic {
    RD_IDLE,
    RD_SEND
  } rd_state_e;

  // Reverse the low nbits of value; upper bits of the result are zero.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int unsigned nbits);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < nbits; i++) begin
      r[5'(i)] = value[5'(nbits - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_pingpong_mem.sv
// Two-bank frame buffer. Four scattered write ports (one per FFT lane, all
// into the same bank) and four contiguous combinational read ports returning
// words 4*beat .. 4*beat+3 of the selected bank.
// Ports:
//   clk          - clock
//   i_we         - write all four lanes this cycle
//   i_wr_bank    - bank written
//   i_wr_addr    - per-lane word address inside the bank
//   i_wr_data    - per-lane write data
//   i_rd_bank    - bank read
//   i_rd_beat    - output beat index (selects four consecutive words)
//   o_rd_data_c  - combinational read data, lane l = word 4*beat+l
module fft_pingpong_mem
  import fft_pkg::*;
#(
  parameter int unsigned W     = 2 * NBITS_OUT_DEF,
  parameter int unsigned N     = N_DEF,
  parameter int unsigned LOG2N = $clog2(N)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic             i_wr_bank,
  input  logic [LOG2N-1:0] i_wr_addr   [LANES],
  input  logic [W-1:0]     i_wr_data   [LANES],
  input  logic             i_rd_bank,
  input  logic [LOG2N-3:0] i_rd_beat,
  output logic [W-1:0]     o_rd_data_c [LANES]
);

  logic [W-1:0] mem_q [2][N];

  // Storage is not reset; the full flags in the controller qualify contents.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int l = 0; l < int'(LANES); l++) begin
        mem_q[i_wr_bank][i_wr_addr[l]] <= i_wr_data[l];
      end
    end
  end

  // Contiguous read of one output beat.
  always_comb begin
    for (int l = 0; l < int'(LANES); l++) begin
      o_rd_data_c[l] = mem_q[i_rd_bank][{i_rd_beat, 2'(l)}];
    end
  end

endmodule

// File: rtl/fft_out_reorder.sv
// Undoes the bit-reversed output order of the 4-lane FFT. Each input beat's
// four lanes are scattered into a ping-pong bank at their natural bin
// positions; full banks are streamed out four bins per beat in natural order
// over valid/ready. A frame arriving while its target bank is still full is
// dropped whole and flagged on the sticky o_overflow.
// Ports:
//   clk, rst          - clock, asynchronous active-low reset
//   i_enable          - input beat valid (FFT o_enable)
//   i_fft0_up .. i_fft1_down - lanes 0..3, {re, im}
//   i_ready           - downstream accepts current output beat
//   o_data0..o_data3  - natural-order bins 4m..4m+3 of output beat m
//   o_valid, o_sof, o_eof - beat valid, first beat, last beat of a frame
//   o_overflow        - sticky frame-dropped flag
module fft_out_reorder
  import fft_pkg::*;
#(
  parameter int unsigned NBITS_out = NBITS_OUT_DEF,
  parameter int unsigned N         = N_DEF,
  parameter int unsigned LOG2N     = $clog2(N)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_enable,
  input  logic [2*NBITS_out-1:0] i_fft0_up,
  input  logic [2*NBITS_out-1:0] i_fft0_down,
  input  logic [2*NBITS_out-1:0] i_fft1_up,
  input  logic [2*NBITS_out-1:0] i_fft1_down,
  input  logic                   i_ready,
  output logic [2*NBITS_out-1:0] o_data0,
  output logic [2*NBITS_out-1:0] o_data1,
  output logic [2*NBITS_out-1:0] o_data2,
  output logic [2*NBITS_out-1:0] o_data3,
  output logic                   o_valid,
  output logic                   o_sof,
  output logic                   o_eof,
  output logic                   o_overflow
);

  localparam int unsigned   W         = 2 * NBITS_out;
  localparam int unsigned   CW        = LOG2N - 2;
  localparam logic [CW-1:0] LAST_BEAT = CW'(N / LANES - 1);

  logic [W-1:0]     lane_c [LANES];

  wr_state_e        wr_state_q, wr_state_d;
  logic [CW-1:0]    wr_cnt_q, wr_cnt_d;
  logic             wr_bank_q, wr_bank_d;
  logic [1:0]       full_q, full_d;
  logic             overflow_q, overflow_d;

  rd_state_e        rd_state_q, rd_state_d;
  logic [CW-1:0]    rd_cnt_q, rd_cnt_d, rd_nxt_c;
  logic             rd_bank_q, rd_bank_d;
  logic             valid_q, valid_d;
  logic             sof_q, sof_d;
  logic             eof_q, eof_d;
  logic [W-1:0]     data_q [LANES];
  logic [W-1:0]     data_d [LANES];

  logic             free_c, load_c, clear_c, sel_bank_c;
  logic [CW-1:0]    sel_beat_c;
  logic             drop_c, we_c;
  logic [LOG2N-1:0] wr_addr_c [LANES];
  logic [W-1:0]     rd_data_c [LANES];

  assign lane_c[0] = i_fft0_up;
  assign lane_c[1] = i_fft0_down;
  assign lane_c[2] = i_fft1_up;
  assign lane_c[3] = i_fft1_down;

  // Arrival index 4*wr_cnt+l lands at its natural bin bitrev(4*wr_cnt+l).
  always_comb begin
    for (int l = 0; l < int'(LANES); l++) begin
      wr_addr_c[l] = LOG2N'(bitrev(32'({wr_cnt_q, 2'(l)}), LOG2N));
    end
  end

  fft_pingpong_mem #(
    .W     (W),
    .N     (N),
    .LOG2N (LOG2N)
  ) u_mem (
    .clk         (clk),
    .i_we        (we_c),
    .i_wr_bank   (wr_bank_q),
    .i_wr_addr   (wr_addr_c),
    .i_wr_data   (lane_c),
    .i_rd_bank   (sel_bank_c),
    .i_rd_beat   (sel_beat_c),
    .o_rd_data_c (rd_data_c)
  );

  // Read FSM: the output registers always hold the beat rd_cnt of rd_bank,
  // so the next beat is fetched from memory in the cycle the current one is
  // accepted.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_cnt_d   = rd_cnt_q;
    rd_bank_d  = rd_bank_q;
    valid_d    = valid_q;
    sof_d      = sof_q;
    eof_d      = eof_q;
    free_c     = 1'b0;
    load_c     = 1'b0;
    clear_c    = 1'b0;
    sel_bank_c = rd_bank_q;
    sel_beat_c = '0;
    rd_nxt_c   = rd_cnt_q + CW'(1);
    case (rd_state_q)
      RD_IDLE: begin
        if (full_q[rd_bank_q]) begin
          rd_state_d = RD_SEND;
          rd_cnt_d   = '0;
          load_c     = 1'b1;
          valid_d    = 1'b1;
          sof_d      = 1'b1;
          eof_d      = 1'b0;
        end
      end
      RD_SEND: begin
        if (i_ready) begin
          if (rd_cnt_q == LAST_BEAT) begin
            free_c    = 1'b1;
            rd_bank_d = ~rd_bank_q;
            rd_cnt_d  = '0;
            if (full_q[~rd_bank_q]) begin
              // Other bank already complete: continue without a bubble.
              sel_bank_c = ~rd_bank_q;
              load_c     = 1'b1;
              sof_d      = 1'b1;
              eof_d      = 1'b0;
            end else begin
              rd_state_d = RD_IDLE;
              clear_c    = 1'b1;
              valid_d    = 1'b0;
              sof_d      = 1'b0;
              eof_d      = 1'b0;
            end
          end else begin
            rd_cnt_d   = rd_nxt_c;
            sel_beat_c = rd_nxt_c;
            load_c     = 1'b1;
            sof_d      = 1'b0;
            eof_d      = (rd_nxt_c == LAST_BEAT);
          end
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // Output data: load a new beat, zero when going idle, else hold.
  always_comb begin
    for (int l = 0; l < int'(LANES); l++) begin
      data_d[l] = data_q[l];
      if (load_c) begin
        data_d[l] = rd_data_c[l];
      end else if (clear_c) begin
        data_d[l] = '0;
      end
    end
  end

  // Write FSM: keep-or-drop is decided at beat 0 and holds for the frame.
  // A bank released by the reader in the same cycle counts as free.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_cnt_d   = wr_cnt_q;
    wr_bank_d  = wr_bank_q;
    full_d     = full_q;
    overflow_d = overflow_q;
    we_c       = 1'b0;
    drop_c     = (wr_state_q == WR_DROP);
    if (free_c) begin
      full_d[rd_bank_q] = 1'b0;
    end
    if (i_enable) begin
      if (wr_cnt_q == '0) begin
        drop_c = full_q[wr_bank_q] && !(free_c && (rd_bank_q == wr_bank_q));
      end
      if (drop_c) begin
        overflow_d = 1'b1;
        wr_state_d = WR_DROP;
      end else begin
        we_c       = 1'b1;
        wr_state_d = WR_WRITE;
      end
      if (wr_cnt_q == LAST_BEAT) begin
        wr_cnt_d   = '0;
        wr_state_d = WR_WRITE;
        if (!drop_c) begin
          full_d[wr_bank_q] = 1'b1;
          wr_bank_d         = ~wr_bank_q;
        end
      end else begin
        wr_cnt_d = wr_cnt_q + CW'(1);
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_state_q <= WR_WRITE;
      wr_cnt_q   <= '0;
      wr_bank_q  <= 1'b0;
      full_q     <= '0;
      overflow_q <= 1'b0;
      rd_state_q <= RD_IDLE;
      rd_cnt_q   <= '0;
      rd_bank_q  <= 1'b0;
      valid_q    <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      for (int l = 0; l < int'(LANES); l++) begin
        data_q[l] <= '0;
      end
    end else begin
      wr_state_q <= wr_state_d;
      wr_cnt_q   <= wr_cnt_d;
      wr_bank_q  <= wr_bank_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      rd_state_q <= rd_state_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_bank_q  <= rd_bank_d;
      valid_q    <= valid_d;
      sof_q      <= sof_d;
      eof_q      <= eof_d;
      for (int l = 0; l < int'(LANES); l++) begin
        data_q[l] <= data_d[l];
      end
    end
  end

  assign o_data0    = data_q[0];
  assign o_data1    = data_q[1];
  assign o_data2    = data_q[2];
  assign o_data3    = data_q[3];
  assign o_valid    = valid_q;
  assign o_sof      = sof_q;
  assign o_eof      = eof_q;
  assign o_overflow = overflow_q;

endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed bench for fft_out_reorder (N=32, 15-bit parts). Input sample at
// arrival index a of frame f is {re = a + 32*f, im = f}; the expected output
// word for natural bin b therefore carries arrival index BR[b] (hand table).
module tb_fft_out_reorder;
  import fft_pkg::*;

  localparam int W = 30;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_enable = 1'b0;
  logic [W-1:0]  i_fft0_up = '0, i_fft0_down = '0, i_fft1_up = '0, i_fft1_down = '0;
  logic          i_ready = 1'b0;
  logic [W-1:0]  o_data0, o_data1, o_data2, o_data3;
  logic          o_valid, o_sof, o_eof, o_overflow;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Bit-reversal of 0..31 over 5 bits, written out by hand.
  int br_tab [32] = '{0, 16, 8, 24, 4, 20, 12, 28, 2, 18, 10, 26, 6, 22, 14, 30,
                      1, 17, 9, 25, 5, 21, 13, 29, 3, 19, 11, 27, 7, 23, 15, 31};

  typedef struct {
    logic [4*W-1:0] d;
    logic           sof;
    logic           eof;
    int             cyc;
  } cap_t;

  cap_t cap_q[$];

  fft_out_reorder #(.NBITS_out(15), .N(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_enable    (i_enable),
    .i_fft0_up   (i_fft0_up),
    .i_fft0_down (i_fft0_down),
    .i_fft1_up   (i_fft1_up),
    .i_fft1_down (i_fft1_down),
    .i_ready     (i_ready),
    .o_data0     (o_data0),
    .o_data1     (o_data1),
    .o_data2     (o_data2),
    .o_data3     (o_data3),
    .o_valid     (o_valid),
    .o_sof       (o_sof),
    .o_eof       (o_eof),
    .o_overflow  (o_overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted output beat.
  always @(negedge clk) begin
    cap_t c;
    if (rst && o_valid && i_ready) begin
      c.d   = {o_data3, o_data2, o_data1, o_data0};
      c.sof = o_sof;
      c.eof = o_eof;
      c.cyc = cyc;
      cap_q.push_back(c);
    end
  end

  function automatic logic [W-1:0] in_word(int f, int a);
    cplx_t w;
    w.re = 15'(a + 32 * f);
    w.im = 15'(f);
    return w;
  endfunction

  function automatic logic [4*W-1:0] exp_beat(int f, int m);
    return {in_word(f, br_tab[4*m+3]), in_word(f, br_tab[4*m+2]),
            in_word(f, br_tab[4*m+1]), in_word(f, br_tab[4*m])};
  endfunction

  task automatic drive_beat(int f, int k);
    @(posedge clk); #1;
    i_enable    = 1'b1;
    i_fft0_up   = in_word(f, 4*k);
    i_fft0_down = in_word(f, 4*k+1);
    i_fft1_up   = in_word(f, 4*k+2);
    i_fft1_down = in_word(f, 4*k+3);
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk); #1;
      i_enable = 1'b0;
    end
  endtask

  task automatic send_frame(int f, int gap_after, int gap_len);
    for (int k = 0; k < 8; k++) begin
      drive_beat(f, k);
      if (k == gap_after) idle(gap_len);
    end
  endtask

  task automatic wait_caps(int n, int budget, output bit ok);
    for (int i = 0; i < budget; i++) begin
      if (cap_q.size() >= n) break;
      @(negedge clk);
    end
    ok = (cap_q.size() >= n);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      i_enable    = 1'b1;
      i_ready     = 1'($urandom);
      i_fft0_up   = W'($urandom);
      i_fft0_down = W'($urandom);
      i_fft1_up   = W'($urandom);
      i_fft1_down = W'($urandom);
      @(negedge clk);
      total++;
      if ({o_valid, o_sof, o_eof, o_overflow} !== 4'b0000) begin
        bad++;
        $display("FAIL reset_flags: got v/s/e/ovf=%b expected 0000", {o_valid, o_sof, o_eof, o_overflow});
      end
      total++;
      if ({o_data3, o_data2, o_data1, o_data0} !== '0) begin
        bad++;
        $display("FAIL reset_data: got %h expected 0", {o_data3, o_data2, o_data1, o_data0});
      end
    end
    @(posedge clk); #1;
    i_enable = 1'b0;
    i_ready  = 1'b1;
    rst      = 1'b1;
  endtask

  task automatic test_single_frame();
    bit ok;
    cap_q.delete();
    send_frame(0, -1, 0);
    idle(1);
    @(negedge clk);
    total++;
    if (o_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_latency_early: got o_valid=%b expected 0", o_valid);
    end
    @(negedge clk);
    total++;
    if ({o_valid, o_sof} !== 2'b11) begin
      bad++;
      $display("FAIL single_latency: got valid/sof=%b expected 11", {o_valid, o_sof});
    end
    wait_caps(8, 40, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL single_timeout: got %0d beats expected 8", cap_q.size());
    end
    for (int m = 0; m < 8 && m < cap_q.size(); m++) begin
      total++;
      if ({cap_q[m].d, cap_q[m].sof, cap_q[m].eof} !== {exp_beat(0, m), m == 0, m == 7}) begin
        bad++;
        $display("FAIL single_beat%0d: got %h sof=%b eof=%b expected %h", m,
                 cap_q[m].d, cap_q[m].sof, cap_q[m].eof, exp_beat(0, m));
      end
    end
    idle(3);
    total++;
    if (cap_q.size() != 8 || o_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_count: got %0d beats valid=%b expected 8 and 0", cap_q.size(), o_valid);
    end
  endtask

  task automatic test_gapped();
    bit ok;
    cap_q.delete();
    send_frame(1, 4, 3);
    idle(1);
    wait_caps(8, 40, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL gapped_timeout: got %0d beats expected 8", cap_q.size());
    end
    for (int m = 0; m < 8 && m < cap_q.size(); m++) begin
      total++;
      if ({cap_q[m].d, cap_q[m].sof, cap_q[m].eof} !== {exp_beat(1, m), m == 0, m == 7}) begin
        bad++;
        $display("FAIL gapped_beat%0d: got %h expected %h", m, cap_q[m].d, exp_beat(1, m));
      end
    end
  endtask

  task automatic test_streaming();
    bit ok;
    cap_q.delete();
    for (int f = 2; f < 6; f++) send_frame(f, -1, 0);
    idle(1);
    wait_caps(32, 100, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL stream_timeout: got %0d beats expected 32", cap_q.size());
    end
    for (int i = 0; i < 32 && i < cap_q.size(); i++) begin
      total++;
      if ({cap_q[i].d, cap_q[i].sof, cap_q[i].eof} !== {exp_beat(2 + i/8, i%8), i%8 == 0, i%8 == 7}) begin
        bad++;
        $display("FAIL stream_beat%0d: got %h sof=%b eof=%b expected %h", i,
                 cap_q[i].d, cap_q[i].sof, cap_q[i].eof, exp_beat(2 + i/8, i%8));
      end
      total++;
      if (cap_q[i].cyc != cap_q[0].cyc + i) begin
        bad++;
        $display("FAIL stream_gap%0d: got cycle %0d expected %0d", i, cap_q[i].cyc, cap_q[0].cyc + i);
      end
    end
    total++;
    if (o_overflow !== 1'b0) begin
      bad++;
      $display("FAIL stream_overflow: got %b expected 0", o_overflow);
    end
  endtask

  task automatic test_back_pressure();
    bit ok;
    cap_q.delete();
    i_ready = 1'b0;
    send_frame(6, -1, 0);
    for (int k = 0; k < 8; k++) begin
      drive_beat(7, k);
      @(negedge clk);
      if (k >= 1) begin
        total++;
        if ({o_valid, o_sof, o_eof, o_data3, o_data2, o_data1, o_data0} !== {3'b110, exp_beat(6, 0)}) begin
          bad++;
          $display("FAIL hold_k%0d: got v/s/e=%b data=%h expected 110 %h", k,
                   {o_valid, o_sof, o_eof}, {o_data3, o_data2, o_data1, o_data0}, exp_beat(6, 0));
        end
      end
    end
    drive_beat(8, 0);
    @(negedge clk);
    total++;
    if (o_overflow !== 1'b0) begin
      bad++;
      $display("FAIL ovf_before: got %b expected 0", o_overflow);
    end
    drive_beat(8, 1);
    @(negedge clk);
    total++;
    if (o_overflow !== 1'b1) begin
      bad++;
      $display("FAIL ovf_set: got %b expected 1", o_overflow);
    end
    for (int k = 2; k < 8; k++) drive_beat(8, k);
    idle(1);
    i_ready = 1'b1;
    wait_caps(8, 40, ok);
    send_frame(9, -1, 0);
    idle(1);
    wait_caps(24, 120, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL bp_timeout: got %0d beats expected 24", cap_q.size());
    end
    for (int i = 0; i < 24 && i < cap_q.size(); i++) begin
      int f;
      f = (i < 8) ? 6 : (i < 16) ? 7 : 9;
      total++;
      if ({cap_q[i].d, cap_q[i].sof, cap_q[i].eof} !== {exp_beat(f, i%8), i%8 == 0, i%8 == 7}) begin
        bad++;
        $display("FAIL bp_beat%0d: got %h expected %h (frame %0d)", i, cap_q[i].d, exp_beat(f, i%8), f);
      end
    end
    idle(4);
    total++;
    if (cap_q.size() != 24 || o_overflow !== 1'b1) begin
      bad++;
      $display("FAIL bp_end: got %0d beats ovf=%b expected 24 and 1", cap_q.size(), o_overflow);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    idle(2);
    cap_q.delete();
    for (int k = 0; k < 3; k++) drive_beat(10, k);
    drive_beat(10, 3);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({o_valid, o_overflow} !== 2'b00) begin
      bad++;
      $display("FAIL midrst_flags: got valid/ovf=%b expected 00", {o_valid, o_overflow});
    end
    @(posedge clk); #1;
    rst      = 1'b1;
    i_enable = 1'b0;
    send_frame(11, -1, 0);
    idle(1);
    wait_caps(8, 40, ok);
    idle(6);
    total++;
    if (cap_q.size() != 8) begin
      bad++;
      $display("FAIL midrst_count: got %0d beats expected 8", cap_q.size());
    end
    for (int m = 0; m < 8 && m < cap_q.size(); m++) begin
      total++;
      if ({cap_q[m].d, cap_q[m].sof, cap_q[m].eof} !== {exp_beat(11, m), m == 0, m == 7}) begin
        bad++;
        $display("FAIL midrst_beat%0d: got %h expected %h", m, cap_q[m].d, exp_beat(11, m));
      end
    end
    total++;
    if (o_overflow !== 1'b0) begin
      bad++;
      $display("FAIL midrst_overflow: got %b expected 0", o_overflow);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_frame();
    test_gapped();
    test_streaming();
    test_back_pressure();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
